// File: rtl/fpu_pkg.sv
// Shared FPU definitions: status codes, float field widths and the
// encoder FSM state set used by int_to_fp_encoder.
package fpu_pkg;

    localparam int EXP_W   = 10;
    localparam int MANT_W  = 21;
    localparam int FP_BIAS = 511;

    typedef enum logic [3:0] {
        OVERFLOW  = 4'd0,
        UNDERFLOW = 4'd1,
        EXACT     = 4'd2,
        INEXACT   = 4'd3
    } status_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        PACK = 2'd2,
        HOLD = 2'd3
    } enc_state_t;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] frac;
    } fp_word_t;

endpackage

// File: rtl/int_to_fp_encoder_if.sv
// Handshake bundle between an integer producer / float consumer (master)
// and the int_to_fp_encoder (slave).
interface int_to_fp_encoder_if;
    import fpu_pkg::*;

    logic [31:0] int_in;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] data_out;
    status_t     status_out;
    logic        out_valid;
    logic        out_ready;

    modport master (
        output int_in, in_valid, out_ready,
        input  in_ready, data_out, status_out, out_valid
    );

    modport slave (
        input  int_in, in_valid, out_ready,
        output in_ready, data_out, status_out, out_valid
    );
endinterface

// File: rtl/fp_pack_round.sv
// Combinational packer: normalised magnitude + shift count + sign -> float word
// and status. Rounding mode selected by macro FPU_ROUND_NEAREST_EN (default: truncate).
module fp_pack_round
    import fpu_pkg::*;
#(
    parameter int BIAS = FP_BIAS
)
(
    input  logic [31:0] mag,
    input  logic [4:0]  lz,
    input  logic        sign,
    output logic [31:0] data,
    output status_t     status
);

    logic [9:0]        lost_bits;
    logic [MANT_W-1:0] frac_trunc;
    logic [EXP_W-1:0]  exp_base;
    logic [MANT_W-1:0] frac_final;
    logic [EXP_W-1:0]  exp_final;

    // mag[31] is the hidden 1; the next 21 bits are the fraction.
    assign lost_bits  = mag[9:0];
    assign frac_trunc = mag[30:10];
    assign exp_base   = EXP_W'(BIAS + 31) - EXP_W'(lz);

`ifdef FPU_ROUND_NEAREST_EN
    logic            round_up;
    logic [MANT_W:0] frac_sum;

    assign round_up   = (lost_bits > 10'h200) || ((lost_bits == 10'h200) && frac_trunc[0]);
    assign frac_sum   = {1'b0, frac_trunc} + {{MANT_W{1'b0}}, round_up};
    // An all-ones fraction rounding up wraps to zero and bumps the exponent.
    assign frac_final = frac_sum[MANT_W-1:0];
    assign exp_final  = exp_base + {{(EXP_W-1){1'b0}}, frac_sum[MANT_W]};
`else
    assign frac_final = frac_trunc;
    assign exp_final  = exp_base;
`endif

    always_comb begin
        data   = '0;
        status = EXACT;
        if (mag != '0) begin
            data   = {sign, exp_final, frac_final};
            status = (lost_bits != '0) ? INEXACT : EXACT;
        end
    end

endmodule

// File: rtl/int_to_fp_encoder.sv
// Iterative integer -> float encoder (one normalising shift per cycle).
// Rounding mode is chosen in fp_pack_round via macro FPU_ROUND_NEAREST_EN.
module int_to_fp_encoder
    import fpu_pkg::*;
#(
    parameter int BIAS      = FP_BIAS,
    parameter bit SIGNED_IN = 1'b1
)
(
    input  logic               clock_100Khz,
    input  logic               reset,
    int_to_fp_encoder_if.slave bus
);

    localparam logic [1:0] ST_IDLE = 2'(IDLE);
    localparam logic [1:0] ST_NORM = 2'(NORM);
    localparam logic [1:0] ST_PACK = 2'(PACK);
    localparam logic [1:0] ST_HOLD = 2'(HOLD);

    logic [1:0]  state_reg,     state_next;
    logic [31:0] mag_reg,       mag_next;
    logic [4:0]  lz_reg,        lz_next;
    logic        sign_reg,      sign_next;
    logic [31:0] data_reg,      data_next;
    status_t     status_reg,    status_next;
    logic        out_valid_reg, out_valid_next;

    logic        in_neg;
    logic [31:0] pack_data;
    status_t     pack_status;

    fp_pack_round #(
        .BIAS (BIAS)
    ) u_pack (
        .mag    (mag_reg),
        .lz     (lz_reg),
        .sign   (sign_reg),
        .data   (pack_data),
        .status (pack_status)
    );

    // -2^31 negates to itself, which read as unsigned is exactly 0x8000_0000.
    assign in_neg = SIGNED_IN && bus.int_in[31];

    always_comb begin
        state_next     = state_reg;
        mag_next       = mag_reg;
        lz_next        = lz_reg;
        sign_next      = sign_reg;
        data_next      = data_reg;
        status_next    = status_reg;
        out_valid_next = out_valid_reg;

        case (state_reg)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    sign_next  = in_neg;
                    mag_next   = in_neg ? (~bus.int_in + 32'd1) : bus.int_in;
                    lz_next    = '0;
                    state_next = ST_NORM;
                end
            end
            ST_NORM: begin
                if (mag_reg[31] || (mag_reg == '0)) begin
                    state_next = ST_PACK;
                end else begin
                    mag_next = mag_reg << 1;
                    lz_next  = lz_reg + 5'd1;
                end
            end
            ST_PACK: begin
                data_next      = pack_data;
                status_next    = pack_status;
                out_valid_next = 1'b1;
                state_next     = ST_HOLD;
            end
            ST_HOLD: begin
                // data_out is left as-is after the handshake; only valid drops.
                if (bus.out_ready) begin
                    out_valid_next = 1'b0;
                    state_next     = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_100Khz) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            mag_reg       <= '0;
            lz_reg        <= '0;
            sign_reg      <= 1'b0;
            data_reg      <= '0;
            status_reg    <= EXACT;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            mag_reg       <= mag_next;
            lz_reg        <= lz_next;
            sign_reg      <= sign_next;
            data_reg      <= data_next;
            status_reg    <= status_next;
            out_valid_reg <= out_valid_next;
        end
    end

    assign bus.in_ready   = (state_reg == ST_IDLE);
    assign bus.data_out   = data_reg;
    assign bus.status_out = status_reg;
    assign bus.out_valid  = out_valid_reg;

endmodule
